// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// 32 shift-add (multiply) or restoring (divide) iterations run on |a|,|b|.
// A final FIX cycle applies the sign correction and writes HI/LO.
// Optional feature: define MULDIV_ABORT_EN to add an `abort` input.
// When asserted, abort cancels an in-flight operation without touching HI/LO.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
`ifdef MULDIV_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t state_q, state_d;

  logic              is_div;       // latched op[1]
  logic              sa, sb;       // operand signs (0 for unsigned ops)
  logic [XLEN-1:0]   mb;           // multiplicand or divisor magnitude
  logic [XLEN-1:0]   araw;         // original dividend for divide-by-zero
  logic [2*XLEN-1:0] acc;          // {hi part, lo part} working register
  logic [CNT_W-1:0]  cnt;

  logic abort_i;
`ifdef MULDIV_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Operand magnitudes at the start edge; op[0]=0 selects signed forms.
  logic            sgn;
  logic [XLEN-1:0] a_abs, b_abs;
  assign sgn   = ~op[0];
  assign a_abs = (sgn && a[XLEN-1]) ? -a : a;
  assign b_abs = (sgn && b[XLEN-1]) ? -b : b;

  // One multiply step: conditionally add the multiplicand to the upper half, shift right.
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_nxt;
  assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mb : {XLEN{1'b0}})};
  assign mul_nxt = {msum, acc[XLEN-1:1]};

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  logic [XLEN:0]     drem, ddiff;
  logic              dge;
  logic [2*XLEN-1:0] div_nxt;
  assign drem    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign dge     = drem >= {1'b0, mb};
  assign ddiff   = drem - {1'b0, mb};
  assign div_nxt = dge ? {ddiff[XLEN-1:0], acc[XLEN-2:0], 1'b1}
                       : {drem[XLEN-1:0],  acc[XLEN-2:0], 1'b0};

  // Sign-corrected results for the FIX cycle.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res_hi, res_lo;
  assign prod = (sa ^ sb) ? -acc : acc;
  assign quo  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (is_div) begin
      if (mb == '0) begin
        res_hi = araw;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  logic accept, fix_wr, mt_ok;
  assign accept = (state_q == S_IDLE) && start;
  assign fix_wr = (state_q == S_FIX) && !abort_i;
  assign mt_ok  = (state_q == S_IDLE) && !start;
  assign busy   = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: IDLE -> CALC (32 steps) -> FIX -> IDLE; abort cancels any busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt == LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Datapath: latch operands on accept, iterate in CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      mb     <= '0;
      araw   <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      is_div <= op[1];
      sa     <= sgn & a[XLEN-1];
      sb     <= sgn & b[XLEN-1];
      mb     <= op[1] ? b_abs : a_abs;
      araw   <= a;
      acc    <= {{XLEN{1'b0}}, (op[1] ? a_abs : b_abs)};
      cnt    <= '0;
    end else if (state_q == S_CALC) begin
      acc <= is_div ? div_nxt : mul_nxt;
      cnt <= cnt + 1'b1;
    end
  end

  // HI/LO: operation results win; MTHI/MTLO only when idle with no start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= fix_wr;
      if (fix_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (mt_ok) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of the 32-bit operand select muxes in EX; consumes the selected operand pair.
- Implements MULT, MULTU, DIV and DIVU, plus MTHI/MTLO writes.
- Control stalls the pipeline on busy and reads hi/lo for MFHI/MFLO.

Parameters:
- XLEN, 32, operand width; HI/LO are each XLEN bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == XLEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  XLEN  operand rs (multiplicand or dividend).
- b  input  XLEN  operand rt (multiplier or divisor).
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wdata  input  XLEN  MTHI/MTLO write data.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse: HI/LO were just updated by an operation.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
- Reset (asynchronous, rst=1):
  - state goes to IDLE.
  - hi=0, lo=0, busy=0, done=0; counter and internal datapath registers are cleared.
  - Reset mid-operation discards all partial work; no done pulse is produced.
- FSM states: IDLE, CALC, FIX.
  - IDLE: if start=1 at an edge, latch op, |a|, |b| and the sign flags (signed ops only; unsigned ops latch raw values). Clear the counter and go to CALC.
  - CALC: one iteration per edge; after the 32nd iteration (counter==31) go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse done, return to IDLE.
- Multiply:
  - Radix-2 shift-add over a 64-bit accumulator.
  - Result: hi = product[63:32], lo = product[31:0].
  - Signed: negate the 64-bit product if the signs of a and b differ.
- Divide:
  - Restoring divide; lo = quotient, hi = remainder.
  - Signed: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Divide by zero (b==0, DIV or DIVU): lo=32'hFFFFFFFF, hi=a (original, uncorrected); same latency.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Timing, with start sampled at the edge ending cycle 0:
  - busy=1 in cycles 1..33.
  - done=1 and new hi/lo visible in cycle 34; busy=0 in cycle 34.
  - A new start may be sampled at the edge ending cycle 34 (back-to-back operations).
- Operands a, b and op are ignored after the start edge; they may change freely.
- start while busy is ignored; there is no queueing.
- hi_we/lo_we:
  - Honoured only when busy=0 and start=0; the register updates at the next edge.
  - Ignored while busy.
  - start together with a write strobe in IDLE: start wins and the write is dropped.
  - hi_we and lo_we may both be asserted together; each writes its own register.
- hi/lo hold their values at all other times.
- done is never high while busy=1.

Optional Feature:
- Macro: MULDIV_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge while busy: return to IDLE, busy=0 in the next cycle, hi/lo unchanged, no done pulse.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start is accepted.
- Undefined: no abort port; every accepted operation runs to completion.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0x00000002 -> done in cycle 34; hi=0x00000001, lo=0xFFFFFFFE; busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- In IDLE: hi_we=1, wdata=0x12345678 -> hi=0x12345678 next cycle. During busy: start=1 with hi_we=1 -> no new operation, hi unchanged until done.
- MULTU 5*6 started, rst=1 asserted in cycle 10 -> busy=0, hi=lo=0 immediately, no done pulse. After release, DIVU 30/4 -> lo=7, hi=2.
- With MULDIV_ABORT_EN: hi preset to 0xAAAA0000, start MULTU, abort in cycle 20 -> busy=0 in cycle 21, hi=0xAAAA0000 unchanged, done never asserted.
